alu_arbiter: RTL and testbench

- Shares the single execute-stage ALU between two requesters: req 0 is the execute/issue path, req 1 is the prefetch/branch-predict address path.
- Arbitrates round-robin and drives the ALU's operand1/operand2/opcode/en inputs.
- Tracks in-flight operations through the ALU's fixed pipeline latency and routes each result/overflow back to the requester that issued it.
- Sits between the decode/prefetch logic and the ALU instance.

---
 rtl/alu_arbiter.sv | 206 ++++++++++++++++++++
 tb/tb_alu_arbiter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//
// Shares one execute-stage ALU between two requesters:
//   requester 0 - execute/issue path
//   requester 1 - prefetch/branch-predict address path
// Arbitration is round-robin with one grant per cycle. The granted operation is
// driven combinationally onto the ALU inputs. A tag pipeline as deep as the ALU
// latency follows each operation, so its result and overflow flag are routed
// back to the requester that issued it.
//
// Parameters:
//   DATA_WIDTH   operand/result width
//   ALU_LATENCY  cycles from the ALU enable cycle to a valid result (1..4)
//
// Ports:
//   clk, rst                      clock (rising edge), synchronous active-high reset
//   reqN_valid / reqN_ready       request handshake (ready is combinational)
//   reqN_op1 / reqN_op2 / reqN_opcode   operation payload
//   rspN_valid                    one-cycle response pulse for requester N
//   rsp_result / rsp_overflow     shared response bus, zero when no response
//   alu_operand1/2, alu_opcode, alu_en   drive the ALU instance
//   alu_result / alu_overflow     returned by the ALU
//   busy                          one or more operations in flight
//
// Optional feature, enabled by defining ALU_ARB_STICKY_OVF_EN:
//   ovf_clr                       clears both sticky overflow flags
//   ovf_sticky0 / ovf_sticky1     latch an overflowing response per requester
// -----------------------------------------------------------------------------
module alu_arbiter #(
  parameter int DATA_WIDTH  = 32,
  parameter int ALU_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [DATA_WIDTH-1:0] req0_op1,
  input  logic [DATA_WIDTH-1:0] req0_op2,
  input  logic [2:0]            req0_opcode,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [DATA_WIDTH-1:0] req1_op1,
  input  logic [DATA_WIDTH-1:0] req1_op2,
  input  logic [2:0]            req1_opcode,
  output logic                  rsp0_valid,
  output logic                  rsp1_valid,
  output logic [DATA_WIDTH-1:0] rsp_result,
  output logic                  rsp_overflow,
  output logic [DATA_WIDTH-1:0] alu_operand1,
  output logic [DATA_WIDTH-1:0] alu_operand2,
  output logic [2:0]            alu_opcode,
  output logic                  alu_en,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic                  alu_overflow,
  output logic                  busy
`ifdef ALU_ARB_STICKY_OVF_EN
  ,
  input  logic                  ovf_clr,
  output logic                  ovf_sticky0,
  output logic                  ovf_sticky1
`endif
);

  // last_grant_r = 1 means requester 1 was granted last, so requester 0 wins a tie.
  logic                   last_grant_r;
  logic                   grant0_s;
  logic                   grant1_s;
  logic                   xfer_s;
  logic                   grant_id_s;
  logic [ALU_LATENCY-1:0] tag_valid_r;
  logic [ALU_LATENCY-1:0] tag_id_r;
  logic                   rsp_hit_s;
  logic                   rsp_id_s;

  // Round-robin grant decision; valids are ignored while in reset.
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if (rst) begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end else if (req0_valid && req1_valid) begin
      if (last_grant_r) begin
        grant0_s = 1'b1;
      end else begin
        grant1_s = 1'b1;
      end
    end else if (req0_valid) begin
      grant0_s = 1'b1;
    end else if (req1_valid) begin
      grant1_s = 1'b1;
    end else begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end
  end

  assign req0_ready = grant0_s;
  assign req1_ready = grant1_s;
  // A grant implies valid, so every grant is a transfer.
  assign xfer_s     = grant0_s | grant1_s;
  assign grant_id_s = grant1_s;

  // Issue mux: the granted requester's operation goes straight to the ALU.
  always_comb begin
    alu_en       = 1'b0;
    alu_operand1 = {DATA_WIDTH{1'b0}};
    alu_operand2 = {DATA_WIDTH{1'b0}};
    alu_opcode   = 3'b000;
    if (grant0_s) begin
      alu_en       = 1'b1;
      alu_operand1 = req0_op1;
      alu_operand2 = req0_op2;
      alu_opcode   = req0_opcode;
    end else if (grant1_s) begin
      alu_en       = 1'b1;
      alu_operand1 = req1_op1;
      alu_operand2 = req1_op2;
      alu_opcode   = req1_opcode;
    end else begin
      alu_en       = 1'b0;
      alu_operand1 = {DATA_WIDTH{1'b0}};
      alu_operand2 = {DATA_WIDTH{1'b0}};
      alu_opcode   = 3'b000;
    end
  end

  // Round-robin pointer: moves only when an operation is actually issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_r <= 1'b1;
    end else if (xfer_s) begin
      last_grant_r <= grant_id_s;
    end else begin
      last_grant_r <= last_grant_r;
    end
  end

  // Tag pipeline: follows each issued operation through the ALU latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_valid_r <= {ALU_LATENCY{1'b0}};
      tag_id_r    <= {ALU_LATENCY{1'b0}};
    end else begin
      tag_valid_r[0] <= xfer_s;
      tag_id_r[0]    <= grant_id_s;
      for (int i = 1; i < ALU_LATENCY; i++) begin
        tag_valid_r[i] <= tag_valid_r[i-1];
        tag_id_r[i]    <= tag_id_r[i-1];
      end
    end
  end

  // Gating with rst keeps results that were in flight at reset from escaping.
  assign rsp_hit_s = tag_valid_r[ALU_LATENCY-1] & ~rst;
  assign rsp_id_s  = tag_id_r[ALU_LATENCY-1];
  assign busy      = (|tag_valid_r) & ~rst;

  // Response routing: ALU result passes through only while a tag retires.
  always_comb begin
    rsp0_valid   = 1'b0;
    rsp1_valid   = 1'b0;
    rsp_result   = {DATA_WIDTH{1'b0}};
    rsp_overflow = 1'b0;
    if (rsp_hit_s) begin
      rsp0_valid   = ~rsp_id_s;
      rsp1_valid   = rsp_id_s;
      rsp_result   = alu_result;
      rsp_overflow = alu_overflow;
    end else begin
      rsp0_valid   = 1'b0;
      rsp1_valid   = 1'b0;
      rsp_result   = {DATA_WIDTH{1'b0}};
      rsp_overflow = 1'b0;
    end
  end

`ifdef ALU_ARB_STICKY_OVF_EN
  // Sticky overflow flags; a new overflow takes priority over ovf_clr.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_sticky0 <= 1'b0;
      ovf_sticky1 <= 1'b0;
    end else begin
      if (rsp0_valid && rsp_overflow) begin
        ovf_sticky0 <= 1'b1;
      end else if (ovf_clr) begin
        ovf_sticky0 <= 1'b0;
      end else begin
        ovf_sticky0 <= ovf_sticky0;
      end
      if (rsp1_valid && rsp_overflow) begin
        ovf_sticky1 <= 1'b1;
      end else if (ovf_clr) begin
        ovf_sticky1 <= 1'b0;
      end else begin
        ovf_sticky1 <= ovf_sticky1;
      end
    end
  end
`else
  // Default build carries no sticky overflow state.
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
//
// Two arbiter instances (ALU latency 1 and 3) share the same requester
// stimulus, each with its own registered ALU stub. Expected responses are
// queued when a grant is expected and popped when they fall due.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;

  localparam int DW = 32;
  localparam int LA = 1;
  localparam int LB = 3;

  typedef struct {
    int          due;
    logic        id;
    logic [31:0] res;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          req0_valid, req1_valid;
  logic [DW-1:0] req0_op1, req0_op2, req1_op1, req1_op2;
  logic [2:0]    req0_opcode, req1_opcode;

  logic          a_req0_ready, a_req1_ready, a_rsp0_valid, a_rsp1_valid, a_rsp_overflow;
  logic          a_alu_en, a_alu_overflow, a_busy;
  logic [DW-1:0] a_rsp_result, a_alu_operand1, a_alu_operand2, a_alu_result;
  logic [2:0]    a_alu_opcode;

  logic          b_req0_ready, b_req1_ready, b_rsp0_valid, b_rsp1_valid, b_rsp_overflow;
  logic          b_alu_en, b_alu_overflow, b_busy;
  logic [DW-1:0] b_rsp_result, b_alu_operand1, b_alu_operand2, b_alu_result;
  logic [2:0]    b_alu_opcode;

`ifdef ALU_ARB_STICKY_OVF_EN
  logic ovf_clr;
  logic a_ovf_sticky0, a_ovf_sticky1, b_ovf_sticky0, b_ovf_sticky1;
  logic sa0 = 1'b0, sa1 = 1'b0, sb0 = 1'b0, sb1 = 1'b0;
`endif

  exp_t qa[$];
  exp_t qb[$];
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  logic mon_on   = 1'b0;

  alu_arbiter #(.DATA_WIDTH(DW), .ALU_LATENCY(LA)) u_dut_a (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(a_req0_ready), .req0_op1(req0_op1),
    .req0_op2(req0_op2), .req0_opcode(req0_opcode),
    .req1_valid(req1_valid), .req1_ready(a_req1_ready), .req1_op1(req1_op1),
    .req1_op2(req1_op2), .req1_opcode(req1_opcode),
    .rsp0_valid(a_rsp0_valid), .rsp1_valid(a_rsp1_valid),
    .rsp_result(a_rsp_result), .rsp_overflow(a_rsp_overflow),
    .alu_operand1(a_alu_operand1), .alu_operand2(a_alu_operand2),
    .alu_opcode(a_alu_opcode), .alu_en(a_alu_en),
    .alu_result(a_alu_result), .alu_overflow(a_alu_overflow),
    .busy(a_busy)
`ifdef ALU_ARB_STICKY_OVF_EN
    , .ovf_clr(ovf_clr), .ovf_sticky0(a_ovf_sticky0), .ovf_sticky1(a_ovf_sticky1)
`endif
  );

  alu_arbiter #(.DATA_WIDTH(DW), .ALU_LATENCY(LB)) u_dut_b (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(b_req0_ready), .req0_op1(req0_op1),
    .req0_op2(req0_op2), .req0_opcode(req0_opcode),
    .req1_valid(req1_valid), .req1_ready(b_req1_ready), .req1_op1(req1_op1),
    .req1_op2(req1_op2), .req1_opcode(req1_opcode),
    .rsp0_valid(b_rsp0_valid), .rsp1_valid(b_rsp1_valid),
    .rsp_result(b_rsp_result), .rsp_overflow(b_rsp_overflow),
    .alu_operand1(b_alu_operand1), .alu_operand2(b_alu_operand2),
    .alu_opcode(b_alu_opcode), .alu_en(b_alu_en),
    .alu_result(b_alu_result), .alu_overflow(b_alu_overflow),
    .busy(b_busy)
`ifdef ALU_ARB_STICKY_OVF_EN
    , .ovf_clr(ovf_clr), .ovf_sticky0(b_ovf_sticky0), .ovf_sticky1(b_ovf_sticky1)
`endif
  );

  // ALU behaviour: opcode 001 adds with carry-out as overflow, others XOR.
  function automatic logic [32:0] alu_fn(input logic [31:0] x, input logic [31:0] y,
                                         input logic [2:0] op);
    case (op)
      3'b001:  return {1'b0, x} + {1'b0, y};
      default: return {1'b0, x ^ y};
    endcase
  endfunction

  // Latency-1 registered ALU stub.
  logic [32:0] pipe_a;
  always @(posedge clk) pipe_a <= alu_fn(a_alu_operand1, a_alu_operand2, a_alu_opcode);
  assign a_alu_result   = pipe_a[31:0];
  assign a_alu_overflow = pipe_a[32];

  // Latency-3 registered ALU stub.
  logic [32:0] pipe_b [3];
  always @(posedge clk) begin
    pipe_b[0] <= alu_fn(b_alu_operand1, b_alu_operand2, b_alu_opcode);
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
  end
  assign b_alu_result   = pipe_b[2][31:0];
  assign b_alu_overflow = pipe_b[2][32];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input logic [63:0] obs, input logic [63:0] expv, input string tag);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One directed cycle: check grants and ALU drive, queue expected responses.
  task automatic tick(input logic e0, input logic e1, input string tag);
    logic [32:0] r;
    logic [31:0] x1, x2;
    logic [2:0]  xo;
    @(negedge clk);
    x1 = e0 ? req0_op1    : (e1 ? req1_op1    : 32'h0);
    x2 = e0 ? req0_op2    : (e1 ? req1_op2    : 32'h0);
    xo = e0 ? req0_opcode : (e1 ? req1_opcode : 3'b000);
    chk(64'(a_req0_ready), 64'(e0), {tag, "/a_ready0"});
    chk(64'(a_req1_ready), 64'(e1), {tag, "/a_ready1"});
    chk(64'(a_alu_en), 64'(e0 | e1), {tag, "/a_en"});
    chk(64'(a_alu_operand1), 64'(x1), {tag, "/a_op1"});
    chk(64'(a_alu_operand2), 64'(x2), {tag, "/a_op2"});
    chk(64'(a_alu_opcode), 64'(xo), {tag, "/a_opc"});
    chk(64'(b_req0_ready), 64'(e0), {tag, "/b_ready0"});
    chk(64'(b_req1_ready), 64'(e1), {tag, "/b_ready1"});
    chk(64'(b_alu_en), 64'(e0 | e1), {tag, "/b_en"});
    chk(64'(b_alu_operand1), 64'(x1), {tag, "/b_op1"});
    chk(64'(b_alu_opcode), 64'(xo), {tag, "/b_opc"});
    if (e0 | e1) begin
      r = alu_fn(x1, x2, xo);
      qa.push_back('{cyc + LA, e1, r[31:0], r[32]});
      qb.push_back('{cyc + LB, e1, r[31:0], r[32]});
    end
    @(posedge clk);
    #1;
  endtask

  // Response monitor for the latency-1 instance.
  always @(negedge clk) begin : mon_a
    exp_t        e;
    logic        ev0, ev1, eo, eb;
    logic [31:0] er;
    ev0 = 1'b0; ev1 = 1'b0; eo = 1'b0; er = 32'h0;
    eb  = (qa.size() > 0) && (qa[0].due <= cyc + LA - 1);
    if (qa.size() > 0 && qa[0].due == cyc) begin
      e = qa.pop_front();
      ev0 = ~e.id; ev1 = e.id; er = e.res; eo = e.ovf;
    end
    if (mon_on) begin
      chk(64'(a_rsp0_valid), 64'(ev0), "a_rsp0_valid");
      chk(64'(a_rsp1_valid), 64'(ev1), "a_rsp1_valid");
      chk(64'(a_rsp_result), 64'(er), "a_rsp_result");
      chk(64'(a_rsp_overflow), 64'(eo), "a_rsp_overflow");
      chk(64'(a_busy), 64'(eb), "a_busy");
`ifdef ALU_ARB_STICKY_OVF_EN
      chk(64'(a_ovf_sticky0), 64'(sa0), "a_sticky0");
      chk(64'(a_ovf_sticky1), 64'(sa1), "a_sticky1");
`endif
    end
`ifdef ALU_ARB_STICKY_OVF_EN
    if (rst) begin sa0 = 1'b0; sa1 = 1'b0; end
    else begin
      if (ev0 && eo) sa0 = 1'b1; else if (ovf_clr) sa0 = 1'b0;
      if (ev1 && eo) sa1 = 1'b1; else if (ovf_clr) sa1 = 1'b0;
    end
`endif
  end

  // Response monitor for the latency-3 instance.
  always @(negedge clk) begin : mon_b
    exp_t        e;
    logic        ev0, ev1, eo, eb;
    logic [31:0] er;
    ev0 = 1'b0; ev1 = 1'b0; eo = 1'b0; er = 32'h0;
    eb  = (qb.size() > 0) && (qb[0].due <= cyc + LB - 1);
    if (qb.size() > 0 && qb[0].due == cyc) begin
      e = qb.pop_front();
      ev0 = ~e.id; ev1 = e.id; er = e.res; eo = e.ovf;
    end
    if (mon_on) begin
      chk(64'(b_rsp0_valid), 64'(ev0), "b_rsp0_valid");
      chk(64'(b_rsp1_valid), 64'(ev1), "b_rsp1_valid");
      chk(64'(b_rsp_result), 64'(er), "b_rsp_result");
      chk(64'(b_rsp_overflow), 64'(eo), "b_rsp_overflow");
      chk(64'(b_busy), 64'(eb), "b_busy");
`ifdef ALU_ARB_STICKY_OVF_EN
      chk(64'(b_ovf_sticky0), 64'(sb0), "b_sticky0");
      chk(64'(b_ovf_sticky1), 64'(sb1), "b_sticky1");
`endif
    end
`ifdef ALU_ARB_STICKY_OVF_EN
    if (rst) begin sb0 = 1'b0; sb1 = 1'b0; end
    else begin
      if (ev0 && eo) sb0 = 1'b1; else if (ovf_clr) sb0 = 1'b0;
      if (ev1 && eo) sb1 = 1'b1; else if (ovf_clr) sb1 = 1'b0;
    end
`endif
  end

  initial begin
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_op1 = 32'h0; req0_op2 = 32'h0; req0_opcode = 3'b000;
    req1_op1 = 32'h0; req1_op2 = 32'h0; req1_opcode = 3'b000;
`ifdef ALU_ARB_STICKY_OVF_EN
    ovf_clr = 1'b0;
`endif
    @(posedge clk);
    #1;
    mon_on = 1'b1;
    tick(1'b0, 1'b0, "rst_idle");
    // Valids presented during reset must be ignored.
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_op1 = 32'h1;  req0_op2 = 32'h2;  req0_opcode = 3'b001;
    req1_op1 = 32'h10; req1_op2 = 32'h33; req1_opcode = 3'b010;
    tick(1'b0, 1'b0, "rst_gate");

    // Both valid continuously: 0 wins the first tie, then strict alternation.
    rst = 1'b0;
    tick(1'b1, 1'b0, "rr0");
    req0_op1 = 32'h7FFF_FFFF; req0_op2 = 32'h1;
    tick(1'b0, 1'b1, "rr1");
    req1_op1 = 32'hAAAA_5555; req1_op2 = 32'h0F0F_0F0F; req1_opcode = 3'b111;
    tick(1'b1, 1'b0, "rr2");
    tick(1'b0, 1'b1, "rr3");
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick(1'b0, 1'b0, "idle0");

    // req0 alone with carry-out.
    req0_valid = 1'b1; req0_op1 = 32'hFFFF_FFFF; req0_op2 = 32'hFFFF_FFFF; req0_opcode = 3'b001;
    tick(1'b1, 1'b0, "ovf0");
    req0_valid = 1'b0;
    tick(1'b0, 1'b0, "idle1");

    // req1 alone three times, then req0 wins the tie, then req1 again.
    req1_valid = 1'b1; req1_opcode = 3'b001;
    for (int i = 0; i < 3; i++) begin
      req1_op1 = 32'(i + 3); req1_op2 = 32'h100;
      tick(1'b0, 1'b1, "solo1");
    end
    req0_valid = 1'b1; req0_op1 = 32'h20; req0_op2 = 32'h22;
    tick(1'b1, 1'b0, "tie0");
    tick(1'b0, 1'b1, "tie1");
    req0_valid = 1'b0; req1_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, "drain0");

    // Single op observed at the three-cycle latency: 5 + 7 = 12.
    req0_valid = 1'b1; req0_op1 = 32'd5; req0_op2 = 32'd7; req0_opcode = 3'b001;
    tick(1'b1, 1'b0, "lat3");
    req0_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, "drain1");

    // Reset one cycle after a grant: in-flight results are discarded.
    req0_valid = 1'b1; req0_op1 = 32'd9; req0_op2 = 32'd9;
    tick(1'b1, 1'b0, "pre_rst");
    req0_valid = 1'b0;
    rst = 1'b1;
    qa.delete();
    qb.delete();
    tick(1'b0, 1'b0, "in_rst");
    rst = 1'b0;
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, "post_rst");

    // Overflowing op on req1, then a clear pulse.
    req1_valid = 1'b1; req1_op1 = 32'h8000_0000; req1_op2 = 32'h8000_0000; req1_opcode = 3'b001;
    tick(1'b0, 1'b1, "ovf1");
    req1_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, "drain2");
`ifdef ALU_ARB_STICKY_OVF_EN
    ovf_clr = 1'b1;
    tick(1'b0, 1'b0, "clr");
    ovf_clr = 1'b0;
`endif
    tick(1'b0, 1'b0, "end0");
    tick(1'b0, 1'b0, "end1");

    chk(64'(qa.size()), 64'd0, "a_pending");
    chk(64'(qb.size()), 64'd0, "b_pending");
    mon_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
